// File: rtl/ins_fetch_ctrl.sv
// Fetch sequencer for a 16-entry instruction file. It keeps an IR and hands it to decode over valid/ready.
// Define HALT_DETECT_EN to enable the HALT state, which is entered when HALT_OPCODE is fetched.
module ins_fetch_ctrl #(
  parameter int                   WORD_SIZE   = 8,
  parameter int                   INDEX_SIZE  = 4,
  parameter logic [WORD_SIZE-1:0] HALT_OPCODE = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic [INDEX_SIZE-1:0] prog_count,
  input  logic [WORD_SIZE-1:0]  ins_val,
  output logic [WORD_SIZE-1:0]  ir_out,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  input  logic                  redirect,
  input  logic [INDEX_SIZE-1:0] redirect_addr,
  output logic                  busy,
  output logic                  halted
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [INDEX_SIZE-1:0]   pc_reg, pc_next;
  logic [WORD_SIZE-1:0]    ir_reg, ir_next;
  logic                    valid_reg, valid_next;
  logic                    load;

  // A redirect always wins over a load, so the instruction on the bus during a redirect is dropped.
  assign load = (!valid_reg || ir_ready) && !redirect;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
      ir_reg    <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    valid_next = valid_reg;
    case (state_reg)
      ST_IDLE: begin
        pc_next    = '0;
        valid_next = 1'b0;
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (redirect) begin
          pc_next    = redirect_addr;
          valid_next = 1'b0;
        end else if (load) begin
          ir_next    = ins_val;
          valid_next = 1'b1;
`ifdef HALT_DETECT_EN
          // The halt instruction is still issued, but the PC stays on it.
          if (ins_val == HALT_OPCODE) state_next = ST_HALT;
          else                        pc_next    = pc_reg + INDEX_SIZE'(1);
`else
          pc_next = pc_reg + INDEX_SIZE'(1);
`endif
        end
      end
`ifdef HALT_DETECT_EN
      ST_HALT: begin
        if (start) begin
          state_next = ST_RUN;
          pc_next    = '0;
          valid_next = 1'b0;
        end else if (ir_ready) begin
          valid_next = 1'b0;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  assign prog_count = pc_reg;
  assign ir_out     = ir_reg;
  assign ir_valid   = valid_reg;
  assign busy       = (state_reg == ST_RUN);
`ifdef HALT_DETECT_EN
  assign halted     = (state_reg == ST_HALT);
`else
  assign halted     = 1'b0;
`endif

endmodule

// File: doc/ins_fetch_ctrl.md
Name: ins_fetch_ctrl

Overview:
Fetch sequencer for the 16-entry, 8-bit instruction register file.
- Drives prog_count into the instruction file and captures the combinational ins_val into an instruction register (IR).
- Presents the IR to decode with a valid/ready handshake, at a throughput of one instruction per cycle.
- Handles branch/jump redirects from execute, plus start and (optionally) halt sequencing.

Parameters:
WORD_SIZE, 8, instruction width in bits
INDEX_SIZE, 4, prog_count width; 2^INDEX_SIZE instructions
HALT_OPCODE, 8'hFF, instruction value treated as halt (used only with HALT_DETECT_EN)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  begin fetching from address 0 (level-sampled)
prog_count  output  INDEX_SIZE  address to instruction file
ins_val  input  WORD_SIZE  instruction read from file at prog_count (combinational)
ir_out  output  WORD_SIZE  current fetched instruction
ir_valid  output  1  ir_out holds a valid instruction
ir_ready  input  1  decode accepts ir_out this cycle
redirect  input  1  load new fetch address, flush IR
redirect_addr  input  INDEX_SIZE  new fetch address
busy  output  1  high in RUN state
halted  output  1  high in HALT state

Behaviour:
- One clock domain. Reset is asynchronous, active-low; reset_n low forces all state immediately:
  - state=IDLE
  - prog_count=0, ir_out=0
  - ir_valid=0, busy=0, halted=0
- States: IDLE, RUN, HALT (HALT reachable only with HALT_DETECT_EN).
- IDLE:
  - prog_count=0, ir_valid=0; redirect ignored.
  - start=1 at edge -> RUN.
- RUN, "load" condition = (!ir_valid || ir_ready) && !redirect. On load:
  - ir_out<=ins_val, ir_valid<=1.
  - prog_count<=prog_count+1, modulo 2^INDEX_SIZE (15 wraps to 0).
- RUN, no redirect and ir_valid && !ir_ready:
  - ir_out, ir_valid and prog_count all hold (stall).
- RUN, redirect=1 has priority over load and ir_ready:
  - prog_count<=redirect_addr, ir_valid<=0; ir_out value is don't-care.
  - The instruction presented in that cycle is discarded even if ir_ready=1.
  - The following cycle fetches from redirect_addr.
- Latency:
  - start sampled at edge E0 -> first instruction (ins[0]) valid after E1, with prog_count=1.
  - Redirect at edge R0 -> ir_valid=0 after R0 -> ins[redirect_addr] valid after R1.
- start while in RUN is ignored.
- busy=1 exactly when state=RUN; halted=1 exactly when state=HALT.
- Handshake rules:
  - ir_out stays stable while ir_valid && !ir_ready, unless redirect is asserted.
  - A transfer occurs on an edge where ir_valid && ir_ready.
- Reset mid-operation: any in-flight IR is lost; restart requires start.

Optional Feature:
Macro HALT_DETECT_EN.
- Defined:
  - On a load where ins_val==HALT_OPCODE: ir_out<=HALT_OPCODE, ir_valid<=1, prog_count does NOT increment, state->HALT.
  - In HALT, no further loads occur. ir_valid clears after the halt instruction transfers (ir_ready=1). redirect is ignored.
  - start=1 in HALT -> prog_count<=0, ir_valid<=0, state->RUN; fetching resumes from address 0 on the next edge.
  - A redirect in the same cycle as the halt load wins: no halt occurs and the redirect is taken.
- Undefined:
  - HALT_OPCODE is fetched like any instruction; the HALT state is absent and halted is tied to 0.

Test Plan:
1. Bench file ins[i]=8'h10+i, reset, start pulse, ir_ready=1 -> ir_valid rises one edge after start is sampled. ir_out sequence is 0x10,0x11,…,0x1F,0x10 (wrap), one per cycle; busy=1.
2. During RUN, hold ir_ready=0 for 3 cycles while ir_out=0x13 -> ir_out=0x13, ir_valid=1, prog_count=4 held all 3 cycles. After release, ir_out=0x14 on the next edge.
3. redirect=1, redirect_addr=9 while ir_out=0x12 valid, with ir_ready=1 in the same cycle -> next cycle ir_valid=0, prog_count=9. The following cycle ir_out=0x19, ir_valid=1, and 0x12 is not double-issued.
4. Redirect during a stall (ir_ready=0, ir_out=0x15) to addr 2 -> IR flushed, then ir_out=0x12.
5. HALT_DETECT_EN with ins[5]=8'hFF, ir_ready=1 ->
   - ir_out=0xFF valid once, then halted=1, ir_valid=0, prog_count=5 frozen.
   - A redirect in HALT is ignored.
   - start -> ir_out=0x10 two edges later.
6. Assert reset_n=0 asynchronously mid-cycle during RUN -> prog_count=0, ir_out=0, ir_valid=0, busy=0 before the next clk edge. Stays in IDLE after release until start.
